// File: rtl/control_sequencer.sv
// control_sequencer: microcoded fetch/decode/execute controller driving every control input of memory_system.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes halt with illegal=1 instead of executing as NOP.
module control_sequencer #(
   parameter logic [2:0] PC_ADDR   = 3'd0,
   parameter logic [2:0] DPTR_ADDR = 3'd2,
   parameter logic [2:0] A_ADDR    = 3'd3,
   parameter logic [2:0] ACC_ADDR  = 3'd5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] instruction,
   input  logic       C,
   input  logic       N,
   input  logic       P,
   input  logic       Z,
   output logic       ir_sclr,
   output logic       mar_sclr,
   output logic       enaf,
   output logic [2:0] selop,
   output logic [1:0] shamt,
   output logic       bank_wr_en,
   output logic [2:0] busB_addr,
   output logic [2:0] busC_addr,
   output logic       ir_en,
   output logic       mar_en,
   output logic       mdr_en,
   output logic       wr_rdn,
   output logic       mdr_alu_n,
   output logic       fetch,
   output logic       halted,
   output logic       illegal
);

   localparam int unsigned OP_W = 5;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [OP_W-1:0] OP_MOV_ACC_A    = 5'b00001;
   localparam logic [OP_W-1:0] OP_MOV_A_ACC    = 5'b00010;
   localparam logic [OP_W-1:0] OP_LD           = 5'b00011;
   localparam logic [OP_W-1:0] OP_ST           = 5'b00100;
   localparam logic [OP_W-1:0] OP_ADD          = 5'b00101;
   localparam logic [OP_W-1:0] OP_SUB          = 5'b00110;
   localparam logic [OP_W-1:0] OP_AND          = 5'b00111;
   localparam logic [OP_W-1:0] OP_OR           = 5'b01000;
   localparam logic [OP_W-1:0] OP_XOR          = 5'b01001;
   localparam logic [OP_W-1:0] OP_NOT          = 5'b01010;
   localparam logic [OP_W-1:0] OP_INC_DPTR     = 5'b01011;
   localparam logic [OP_W-1:0] OP_MOV_DPTR_ACC = 5'b01100;
   localparam logic [OP_W-1:0] OP_JZ           = 5'b01101;
   localparam logic [OP_W-1:0] OP_JC           = 5'b01110;
   localparam logic [OP_W-1:0] OP_UNDEF_LO     = 5'b01111;
   localparam logic [OP_W-1:0] OP_UNDEF_HI     = 5'b11110;
   localparam logic [OP_W-1:0] OP_HALT         = 5'b11111;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_NOT  = 3'b110;
   localparam logic [2:0] ALU_INC  = 3'b111;

   typedef enum logic [2:0] {
      S_RST, S_FETCH0, S_FETCH1, S_DECODE, S_EX0, S_EX1, S_EX2, S_HALT
   } state_t;

   typedef struct packed {
      logic       ir_sclr;
      logic       mar_sclr;
      logic       enaf;
      logic [2:0] selop;
      logic       bank_wr_en;
      logic [2:0] busb;
      logic [2:0] busc;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic       wr_rdn;
      logic       mdr_alu_n;
      logic       fetch;
      logic       halted;
   } ctrl_t;

   state_t          state;
   logic [OP_W-1:0] op_q;
   logic [OP_W-1:0] op_sel;
   ctrl_t           ctrl;

   function automatic logic is_undef(logic [OP_W-1:0] op);
      return (op >= OP_UNDEF_LO) && (op <= OP_UNDEF_HI);
   endfunction

   function automatic logic is_mem(logic [OP_W-1:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

   // One ALU pass from busB into the bank at busC.
   function automatic ctrl_t alu_wr(logic [2:0] b, logic [2:0] sel, logic [2:0] c, logic flags);
      ctrl_t k;
      k            = '0;
      k.busb       = b;
      k.selop      = sel;
      k.busc       = c;
      k.bank_wr_en = 1'b1;
      k.enaf       = flags;
      return k;
   endfunction

   function automatic state_t next_state(state_t st, logic [OP_W-1:0] op);
      state_t nx;
      nx = S_RST;
      case (st)
         S_RST:    nx = S_FETCH0;
         S_FETCH0: nx = S_FETCH1;
         S_FETCH1: nx = S_DECODE;
         S_DECODE: nx = (op == OP_HALT || (TRAP && is_undef(op))) ? S_HALT : S_EX0;
         S_EX0:    nx = is_mem(op) ? S_EX1 : S_FETCH0;
         S_EX1:    nx = S_EX2;
         S_EX2:    nx = S_FETCH0;
         S_HALT:   nx = S_HALT;
         default:  nx = S_RST;
      endcase
      return nx;
   endfunction

   // Control word for the state being entered; flags are sampled when entering EX0.
   function automatic ctrl_t ctrl_for(state_t st, logic [OP_W-1:0] op, logic c, logic z);
      ctrl_t k;
      k = '0;
      case (st)
         S_RST: begin
            k.ir_sclr  = 1'b1;
            k.mar_sclr = 1'b1;
         end
         S_FETCH0: begin
            k.busb   = PC_ADDR;
            k.selop  = ALU_PASS;
            k.mar_en = 1'b1;
            k.fetch  = 1'b1;
         end
         S_FETCH1: begin
            k       = alu_wr(PC_ADDR, ALU_INC, PC_ADDR, 1'b0);
            k.ir_en = 1'b1;
         end
         S_EX0: begin
            case (op)
               OP_MOV_ACC_A:    k = alu_wr(A_ADDR, ALU_PASS, ACC_ADDR, 1'b0);
               OP_MOV_A_ACC:    k = alu_wr(ACC_ADDR, ALU_PASS, A_ADDR, 1'b0);
               OP_LD, OP_ST: begin
                  k.busb   = DPTR_ADDR;
                  k.selop  = ALU_PASS;
                  k.mar_en = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                  k = alu_wr(A_ADDR, 3'(op - 5'd4), ACC_ADDR, 1'b1);
               OP_NOT:          k = alu_wr(ACC_ADDR, ALU_NOT, ACC_ADDR, 1'b1);
               OP_INC_DPTR:     k = alu_wr(DPTR_ADDR, ALU_INC, DPTR_ADDR, 1'b0);
               OP_MOV_DPTR_ACC: k = alu_wr(ACC_ADDR, ALU_PASS, DPTR_ADDR, 1'b0);
               OP_JZ:           if (z) k = alu_wr(DPTR_ADDR, ALU_PASS, PC_ADDR, 1'b0);
               OP_JC:           if (c) k = alu_wr(DPTR_ADDR, ALU_PASS, PC_ADDR, 1'b0);
               default:         k = '0;
            endcase
         end
         S_EX1: begin
            if (op == OP_LD) begin
               k.mdr_en    = 1'b1;
               k.mdr_alu_n = 1'b1;
            end else if (op == OP_ST) begin
               k.busb   = ACC_ADDR;
               k.selop  = ALU_PASS;
               k.mdr_en = 1'b1;
            end
         end
         S_EX2: begin
            if (op == OP_LD) begin
               k.mdr_alu_n  = 1'b1;
               k.bank_wr_en = 1'b1;
               k.busc       = ACC_ADDR;
            end else if (op == OP_ST) begin
               k.wr_rdn = 1'b1;
            end
         end
         S_HALT:  k.halted = 1'b1;
         default: k = '0;
      endcase
      return k;
   endfunction

   // IR is valid during DECODE; afterwards the latched copy steers the execute states.
   assign op_sel = (state == S_DECODE) ? instruction : op_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_RST;
         op_q  <= '0;
         ctrl  <= ctrl_for(S_RST, '0, 1'b0, 1'b0);
      end else begin
         state <= next_state(state, op_sel);
         if (state == S_DECODE) op_q <= instruction;
         ctrl  <= ctrl_for(next_state(state, op_sel), op_sel, C, Z);
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (!rst) illegal_q <= 1'b0;
      else if (state == S_DECODE && is_undef(instruction)) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // N and P are part of the flag interface but no instruction reads them.
   logic unused_flags;
   assign unused_flags = ^{N, P};

   assign ir_sclr    = ctrl.ir_sclr;
   assign mar_sclr   = ctrl.mar_sclr;
   assign enaf       = ctrl.enaf;
   assign selop      = ctrl.selop;
   assign shamt      = 2'b00;
   assign bank_wr_en = ctrl.bank_wr_en;
   assign busB_addr  = ctrl.busb;
   assign busC_addr  = ctrl.busc;
   assign ir_en      = ctrl.ir_en;
   assign mar_en     = ctrl.mar_en;
   assign mdr_en     = ctrl.mdr_en;
   assign wr_rdn     = ctrl.wr_rdn;
   assign mdr_alu_n  = ctrl.mdr_alu_n;
   assign fetch      = ctrl.fetch;
   assign halted     = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small datapath stand-in executes the DUT's control words,
// and an instruction-level model predicts architectural state and per-instruction latency.
`timescale 1ns/1ps
module tb_control_sequencer;

   localparam logic [2:0] PC = 3'd0, DP = 3'd2, RA = 3'd3, AC = 3'd5;
`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] instruction;
   logic       C, N, P, Z;
   logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en;
   logic       wr_rdn, mdr_alu_n, fetch, halted, illegal;
   logic [2:0] selop, busB_addr, busC_addr;
   logic [1:0] shamt;
   logic [20:0] rest_bits;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .rst(rst), .instruction(instruction),
      .C(C), .N(N), .P(P), .Z(Z),
      .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop), .shamt(shamt),
      .bank_wr_en(bank_wr_en), .busB_addr(busB_addr), .busC_addr(busC_addr),
      .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .wr_rdn(wr_rdn),
      .mdr_alu_n(mdr_alu_n), .fetch(fetch), .halted(halted), .illegal(illegal)
   );

   assign rest_bits = {enaf, selop, shamt, bank_wr_en, busB_addr, busC_addr,
                       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, fetch, halted, illegal};

   // ---------------- datapath stand-in ----------------
   logic [7:0] dp_reg [8];
   logic [7:0] dp_mem [256];
   logic [7:0] init_reg [8];
   logic [7:0] init_mem [256];
   logic [7:0] mar, mdr;
   logic [4:0] ir;
   logic       fc, fz, fn, fp, dp_load = 1'b0;
   logic [8:0] alu;
   logic [7:0] busc;

   function automatic logic [8:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         3'd0: return {1'b0, b};
         3'd1: return {1'b0, a} + {1'b0, b};
         3'd2: return {(a < b), 8'(a - b)};
         3'd3: return {1'b0, a & b};
         3'd4: return {1'b0, a | b};
         3'd5: return {1'b0, a ^ b};
         3'd6: return {1'b0, ~b};
         default: return {1'b0, 8'(b + 8'd1)};
      endcase
   endfunction

   always_comb alu  = alu_f(selop, dp_reg[AC], dp_reg[busB_addr]);
   always_comb busc = mdr_alu_n ? mdr : alu[7:0];
   assign instruction = ir;
   assign C = fc;
   assign Z = fz;
   assign N = fn;
   assign P = fp;

   always @(posedge clk) begin
      if (dp_load) begin
         for (int i = 0; i < 8; i++) dp_reg[i] <= init_reg[i];
         for (int i = 0; i < 256; i++) dp_mem[i] <= init_mem[i];
         mar <= 8'd0; mdr <= 8'd0; ir <= 5'd0;
         fc <= 1'b0; fz <= 1'b0; fn <= 1'b0; fp <= 1'b0;
      end else begin
         if (bank_wr_en) dp_reg[busC_addr] <= busc;
         if (mar_sclr) mar <= 8'd0;
         else if (mar_en) mar <= alu[7:0];
         if (ir_sclr) ir <= 5'd0;
         else if (ir_en) ir <= dp_mem[mar][4:0];
         if (mdr_en) mdr <= mdr_alu_n ? dp_mem[mar] : alu[7:0];
         if (wr_rdn) dp_mem[mar] <= mdr;
         if (enaf) begin
            fz <= (alu[7:0] == 8'd0);
            fc <= alu[8];
            fn <= alu[7];
            fp <= ^alu[7:0];
         end
      end
   end

   // ---------------- instruction-level reference ----------------
   logic [7:0] m_mem [256];
   logic [7:0] m_pc, m_dptr, m_a, m_acc;
   logic       m_c, m_z;

   task automatic model_load();
      for (int i = 0; i < 256; i++) m_mem[i] = init_mem[i];
      m_pc = init_reg[PC]; m_dptr = init_reg[DP]; m_a = init_reg[RA]; m_acc = init_reg[AC];
      m_c = 1'b0; m_z = 1'b0;
   endtask

   task automatic model_step(output int cyc, output bit hlt, output bit ill);
      logic [4:0] op;
      logic [8:0] t;
      op = m_mem[m_pc][4:0];
      m_pc = m_pc + 8'd1;
      cyc = 4; hlt = 1'b0; ill = 1'b0;
      case (op)
         5'd0:  ;
         5'd1:  m_acc = m_a;
         5'd2:  m_a = m_acc;
         5'd3:  begin m_acc = m_mem[m_dptr]; cyc = 6; end
         5'd4:  begin m_mem[m_dptr] = m_acc; cyc = 6; end
         5'd5:  begin t = m_acc + m_a; m_acc = t[7:0]; m_c = t[8]; m_z = (m_acc == 0); end
         5'd6:  begin m_c = (m_acc < m_a); m_acc = m_acc - m_a; m_z = (m_acc == 0); end
         5'd7:  begin m_acc = m_acc & m_a; m_c = 1'b0; m_z = (m_acc == 0); end
         5'd8:  begin m_acc = m_acc | m_a; m_c = 1'b0; m_z = (m_acc == 0); end
         5'd9:  begin m_acc = m_acc ^ m_a; m_c = 1'b0; m_z = (m_acc == 0); end
         5'd10: begin m_acc = ~m_acc; m_c = 1'b0; m_z = (m_acc == 0); end
         5'd11: m_dptr = m_dptr + 8'd1;
         5'd12: m_dptr = m_acc;
         5'd13: if (m_z) m_pc = m_dptr;
         5'd14: if (m_c) m_pc = m_dptr;
         5'd31: hlt = 1'b1;
         default: begin hlt = TRAP; ill = TRAP; end
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_init();
      for (int i = 0; i < 8; i++) init_reg[i] = 8'd0;
      for (int i = 0; i < 256; i++) init_mem[i] = 8'd0;
   endtask

   // Loads the datapath, holds reset two cycles, returns sampling in FETCH0.
   task automatic start();
      dp_load = 1'b1; rst = 1'b0;
      tick();
      dp_load = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic run_to_fetch(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (fetch !== 1'b1 && n < budget);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_init();
      dp_load = 1'b1; rst = 1'b0;
      tick();
      dp_load = 1'b0;
      tick();
      n_cmp++;
      if ({ir_sclr, mar_sclr} !== 2'b11) begin
         n_bad++; $display("FAIL reset_sclr: got %b want 11", {ir_sclr, mar_sclr});
      end
      n_cmp++;
      if (rest_bits !== 21'd0) begin
         n_bad++; $display("FAIL reset_others: got %h want 0", rest_bits);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({fetch, mar_en, busB_addr, selop, ir_sclr} !== {2'b11, PC, 3'b000, 1'b0}) begin
         n_bad++; $display("FAIL fetch0: got %b want %b", {fetch, mar_en, busB_addr, selop, ir_sclr},
                           {2'b11, PC, 3'b000, 1'b0});
      end
      tick();
      n_cmp++;
      if ({ir_en, bank_wr_en, busC_addr, busB_addr, selop, enaf, fetch} !== {2'b11, PC, PC, 3'b111, 2'b00}) begin
         n_bad++; $display("FAIL fetch1: got %b want %b", {ir_en, bank_wr_en, busC_addr, busB_addr, selop, enaf, fetch},
                           {2'b11, PC, PC, 3'b111, 2'b00});
      end
      tick();
      n_cmp++;
      if ({ir_sclr, mar_sclr, rest_bits} !== 23'd0) begin
         n_bad++; $display("FAIL decode_idle: got %h want 0", {ir_sclr, mar_sclr, rest_bits});
      end
   endtask

   task automatic test_load();
      int n;
      clear_init();
      init_mem[0] = 8'h03; init_mem[1] = 8'h1f; init_mem[8'h40] = 8'hA5; init_reg[DP] = 8'h40;
      start();
      tick(); tick(); tick();
      n_cmp++;
      if ({mar_en, busB_addr, selop, bank_wr_en} !== {1'b1, DP, 3'b000, 1'b0}) begin
         n_bad++; $display("FAIL load_ex0: got %b want %b", {mar_en, busB_addr, selop, bank_wr_en}, {1'b1, DP, 4'b0000});
      end
      tick();
      n_cmp++;
      if ({mdr_en, mdr_alu_n, wr_rdn} !== 3'b110) begin
         n_bad++; $display("FAIL load_ex1: got %b want 110", {mdr_en, mdr_alu_n, wr_rdn});
      end
      tick();
      n_cmp++;
      if ({mdr_alu_n, bank_wr_en, busC_addr, mdr_en} !== {2'b11, AC, 1'b0}) begin
         n_bad++; $display("FAIL load_ex2: got %b want %b", {mdr_alu_n, bank_wr_en, busC_addr, mdr_en}, {2'b11, AC, 1'b0});
      end
      run_to_fetch(4, n);
      n_cmp++;
      if (n !== 1 || dp_reg[AC] !== 8'hA5) begin
         n_bad++; $display("FAIL load_result: got cyc+%0d acc=%h want cyc+1 acc=a5", n, dp_reg[AC]);
      end
   endtask

   task automatic test_store();
      logic [5:0] wseq;
      clear_init();
      init_mem[0] = 8'h04; init_mem[1] = 8'h1f; init_reg[AC] = 8'h0F; init_reg[DP] = 8'h41;
      start();
      for (int i = 0; i < 6; i++) begin
         wseq[i] = wr_rdn;
         tick();
      end
      n_cmp++;
      if (wseq !== 6'b100000) begin
         n_bad++; $display("FAIL store_wr_rdn: got %b want 100000", wseq);
      end
      n_cmp++;
      if (dp_mem[8'h41] !== 8'h0F || fetch !== 1'b1) begin
         n_bad++; $display("FAIL store_result: got mem=%h fetch=%b want 0f 1", dp_mem[8'h41], fetch);
      end
   endtask

   task automatic test_jump();
      logic [7:0] avals [2];
      logic [7:0] want_pc;
      int n1, n2;
      avals[0] = 8'h80; avals[1] = 8'h01;
      for (int k = 0; k < 2; k++) begin
         clear_init();
         init_mem[0] = 8'h06; init_mem[1] = 8'h0d; init_mem[2] = 8'h1f; init_mem[8'h20] = 8'h1f;
         init_reg[AC] = 8'h80; init_reg[RA] = avals[k]; init_reg[DP] = 8'h20;
         want_pc = (8'(8'h80 - avals[k]) == 8'd0) ? 8'h20 : 8'h02;
         start();
         run_to_fetch(8, n1);
         run_to_fetch(8, n2);
         n_cmp++;
         if (n1 !== 4 || n2 !== 4 || dp_reg[PC] !== want_pc || fz !== (want_pc == 8'h20)) begin
            n_bad++; $display("FAIL jz_a%h: got cyc %0d/%0d pc=%h z=%b want 4/4 pc=%h", avals[k], n1, n2,
                              dp_reg[PC], fz, want_pc);
         end
      end
   endtask

   task automatic test_reset_mid_store();
      logic wr_any;
      clear_init();
      init_mem[0] = 8'h04; init_mem[1] = 8'h1f; init_mem[8'h41] = 8'h77;
      init_reg[AC] = 8'h0F; init_reg[DP] = 8'h41;
      start();
      wr_any = wr_rdn;
      for (int i = 0; i < 4; i++) begin
         tick();
         wr_any |= wr_rdn;
      end
      rst = 1'b0;
      tick();
      wr_any |= wr_rdn;
      n_cmp++;
      if ({ir_sclr, mar_sclr, rest_bits} !== {2'b11, 21'd0}) begin
         n_bad++; $display("FAIL mid_reset_state: got %h want %h", {ir_sclr, mar_sclr, rest_bits}, {2'b11, 21'd0});
      end
      rst = 1'b1;
      tick();
      wr_any |= wr_rdn;
      n_cmp++;
      if (fetch !== 1'b1 || dp_reg[PC] !== 8'h01 || dp_mem[8'h41] !== 8'h77 || wr_any !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_restart: got fetch=%b pc=%h mem=%h wr=%b want 1 01 77 0",
                           fetch, dp_reg[PC], dp_mem[8'h41], wr_any);
      end
   endtask

   task automatic test_illegal();
      clear_init();
      init_mem[0] = 8'h10; init_mem[1] = 8'h1f;
      start();
`ifdef ILLEGAL_TRAP_EN
      begin
         int good;
         good = 0;
         tick(); tick(); tick();
         for (int i = 0; i < 10; i++) begin
            if (halted === 1'b1 && illegal === 1'b1 && fetch === 1'b0) good++;
            tick();
         end
         n_cmp++;
         if (good !== 10) begin
            n_bad++; $display("FAIL illegal_trap: got %0d held cycles want 10", good);
         end
      end
`else
      begin
         int n;
         run_to_fetch(8, n);
         n_cmp++;
         if (n !== 4 || illegal !== 1'b0 || halted !== 1'b0 || dp_reg[PC] !== 8'h01) begin
            n_bad++; $display("FAIL illegal_nop: got cyc=%0d ill=%b halt=%b pc=%h want 4 0 0 01",
                              n, illegal, halted, dp_reg[PC]);
         end
      end
`endif
   endtask

   task automatic test_random_programs();
      int  cyc, n, diffs;
      bit  hlt, ill;
      int  r;
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
         for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 19);
            init_mem[i] = (r < 15) ? 8'(r) : ((r < 18) ? 8'($urandom_range(15, 30)) : 8'h1f);
         end
         for (int i = 0; i < 8; i++) init_reg[i] = 8'($urandom);
         init_reg[PC] = 8'd0;
         init_reg[DP] = 8'($urandom_range(0, 63));
         if ($urandom_range(0, 2) == 0) init_reg[RA] = init_reg[AC];
         model_load();
         start();
         for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (dp_reg[PC] !== m_pc || fetch !== 1'b1) begin
               n_bad++; $display("FAIL rand_pc p%0d i%0d: got pc=%h fetch=%b want %h 1", p, k, dp_reg[PC], fetch, m_pc);
            end
            model_step(cyc, hlt, ill);
            if (hlt) begin
               tick(); tick(); tick();
               n_cmp++;
               if ({halted, illegal, fetch} !== {1'b1, ill, 1'b0}) begin
                  n_bad++; $display("FAIL rand_halt p%0d: got %b want %b", p, {halted, illegal, fetch}, {1'b1, ill, 1'b0});
               end
               break;
            end
            run_to_fetch(10, n);
            n_cmp++;
            if (n !== cyc) begin
               n_bad++; $display("FAIL rand_latency p%0d i%0d: got %0d want %0d", p, k, n, cyc);
            end
         end
         n_cmp++;
         if (dp_reg[AC] !== m_acc || dp_reg[RA] !== m_a || dp_reg[DP] !== m_dptr) begin
            n_bad++; $display("FAIL rand_regs p%0d: got acc=%h a=%h dptr=%h want %h %h %h",
                              p, dp_reg[AC], dp_reg[RA], dp_reg[DP], m_acc, m_a, m_dptr);
         end
         diffs = 0;
         for (int i = 0; i < 256; i++) if (dp_mem[i] !== m_mem[i]) diffs++;
         n_cmp++;
         if (diffs !== 0) begin
            n_bad++; $display("FAIL rand_mem p%0d: got %0d differing bytes want 0", p, diffs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_jump();
      test_reset_mid_store();
      test_illegal();
      test_random_programs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
